// File: rtl/reverse_pkg.sv
// reverse_pkg: shared types and helpers for the digit-reversal engine.
// Optional feature macro used by this slice: REVERSE_PALINDROME_EN.
package reverse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } rev_state_e;

  // Largest number of base-radix digits a width-bit unsigned value can have,
  // i.e. the digit count of 2^width-1. Gives the worst-case digit-step count.
  function automatic int max_digits(input int width, input int radix);
    longint unsigned v;
    int n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v != 64'd0) begin
        v = v / 64'(radix);
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/reverse_digits_if.sv
// reverse_digits_if: start/Done handshake and result bundle of the reverser.
// The palindrome member exists only when REVERSE_PALINDROME_EN is defined.
interface reverse_digits_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             Done;
  logic [WIDTH-1:0] reverse;
  logic             ovf;
`ifdef REVERSE_PALINDROME_EN
  logic             palindrome;
`endif

`ifdef REVERSE_PALINDROME_EN
  modport master (output start, x, input busy, Done, reverse, ovf, palindrome);
  modport slave  (input start, x, output busy, Done, reverse, ovf, palindrome);
`else
  modport master (output start, x, input busy, Done, reverse, ovf);
  modport slave  (input start, x, output busy, Done, reverse, ovf);
`endif

endinterface

// File: rtl/reverse_ctrl.sv
// reverse_ctrl: three-state sequencer (IDLE -> ITER -> DONE) of the reverser.
// It loads the operand, keeps iterating until the working copy is zero, then
// latches the result and emits a one-cycle Done pulse.
module reverse_ctrl
  import reverse_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic x_zero,
  output logic ld_x,
  output logic ld_out,
  output logic busy,
  output logic Done
);

  rev_state_e state, state_nxt;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore/transition strobes for the datapath.
  always_comb begin
    state_nxt = state;
    ld_x      = 1'b0;
    ld_out    = 1'b0;
    busy      = 1'b1;
    Done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          ld_x      = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        if (x_zero) begin
          ld_out    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/reverse_digits.sv
// reverse_digits: reverses the base-RADIX digits of a WIDTH-bit operand, one
// digit per clock. Overflow past WIDTH bits is flagged (result kept modulo
// 2^WIDTH). With REVERSE_PALINDROME_EN defined, a palindrome flag is produced.
module reverse_digits
  import reverse_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RADIX = 10
) (
  input  logic clk,
  input  logic rst_n,
  reverse_digits_if.slave bus
);

  // Four guard bits hold acc*RADIX + digit exactly for any RADIX up to 16.
  localparam int EW = WIDTH + 4;
  localparam logic [EW-1:0] RADIX_E = EW'(RADIX);

  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] acc;
  logic             ovf_acc;
  logic [WIDTH-1:0] reverse_q;
  logic             ovf_q;
`ifdef REVERSE_PALINDROME_EN
  logic [WIDTH-1:0] x_orig;
  logic             pal_q;
`endif

  logic             ld_x;
  logic             ld_out;
  logic             busy;
  logic             done;
  logic             x_zero;
  logic             step;
  logic [EW-1:0]    x_ext;
  logic [EW-1:0]    digit;
  logic [EW-1:0]    next_acc;
  logic [WIDTH-1:0] quot;

  reverse_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bus.start),
    .x_zero (x_zero),
    .ld_x   (ld_x),
    .ld_out (ld_out),
    .busy   (busy),
    .Done   (done)
  );

  assign x_zero   = (x_reg == '0);
  // x_reg is already zero in DONE, so busy alone marks the ITER digit steps.
  assign step     = busy && !x_zero;
  assign x_ext    = {4'b0000, x_reg};
  assign quot     = WIDTH'(x_ext / RADIX_E);
  assign digit    = x_ext % RADIX_E;
  assign next_acc = {4'b0000, acc} * RADIX_E + digit;

  // Working registers: load on accept, then retire one digit per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg   <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (ld_x) begin
      x_reg   <= bus.x;
      acc     <= '0;
      ovf_acc <= 1'b0;
    end else if (step) begin
      x_reg   <= quot;
      acc     <= next_acc[WIDTH-1:0];
      ovf_acc <= ovf_acc | (next_acc[EW-1:WIDTH] != 4'b0000);
    end
  end

  // Result registers: updated only on completion, held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reverse_q <= '0;
      ovf_q     <= 1'b0;
    end else if (ld_out) begin
      reverse_q <= acc;
      ovf_q     <= ovf_acc;
    end
  end

`ifdef REVERSE_PALINDROME_EN
  // Operand copy and palindrome flag; an overflowed result never qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_orig <= '0;
      pal_q  <= 1'b0;
    end else if (ld_x) begin
      x_orig <= bus.x;
    end else if (ld_out) begin
      pal_q  <= (acc == x_orig) && !ovf_acc;
    end
  end

  assign bus.palindrome = pal_q;
`endif

  assign bus.busy    = busy;
  assign bus.Done    = done;
  assign bus.reverse = reverse_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_reverse_digits.sv
// tb_reverse_digits: directed checks of reverse_digits at WIDTH=16/RADIX=10
// and WIDTH=8/RADIX=2. Palindrome checks are compiled with REVERSE_PALINDROME_EN.
module tb_reverse_digits;
  import reverse_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   budget16;
  int   budget8;

  always #5 clk = ~clk;

  reverse_digits_if #(.WIDTH(16)) bus16 ();
  reverse_digits_if #(.WIDTH(8))  bus8 ();

  reverse_digits #(.WIDTH(16), .RADIX(10)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  reverse_digits #(.WIDTH(8), .RADIX(2)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  // Accept one operand on the 16-bit unit and measure cycles until Done.
  // After acceptance x is scribbled to show later changes are ignored.
  task automatic run16(input logic [15:0] val, output int lat, output int busy_cnt);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.x     = val;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.x     = 16'hFFFF;
    lat = 0;
    busy_cnt = 0;
    while (bus16.Done !== 1'b1) begin
      if (bus16.busy === 1'b1) busy_cnt++;
      lat++;
      if (lat > budget16) begin
        $display("[TB] timeout waiting for Done on x=%0d", val);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic [7:0] val, output int lat);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.x     = val;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.x     = 8'hFF;
    lat = 0;
    while (bus8.Done !== 1'b1) begin
      lat++;
      if (lat > budget8) begin
        $display("[TB] timeout waiting for Done on 8-bit x=%0d", val);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus16.busy, bus16.Done, bus16.ovf, bus16.reverse} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL reset16: got busy=%b Done=%b ovf=%b rev=%0d, expected all 0",
               bus16.busy, bus16.Done, bus16.ovf, bus16.reverse);
    end
    vectors++;
    if ({bus8.busy, bus8.Done, bus8.ovf, bus8.reverse} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset8: got busy=%b Done=%b ovf=%b rev=%0d, expected all 0",
               bus8.busy, bus8.Done, bus8.ovf, bus8.reverse);
    end
`ifdef REVERSE_PALINDROME_EN
    vectors++;
    if (bus16.palindrome !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_pal: got %b, expected 0", bus16.palindrome);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    run16(16'd1234, lat, bc);
    vectors++;
    if (bus16.reverse !== 16'd4321) begin
      miscompares++;
      $display("[TB] FAIL basic_rev: got %0d, expected 4321", bus16.reverse);
    end
    vectors++;
    if (bus16.ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_ovf: got %b, expected 0", bus16.ovf);
    end
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d, expected 5", lat);
    end
    vectors++;
    if (bc !== 5) begin
      miscompares++;
      $display("[TB] FAIL basic_busy_before_done: got %0d, expected 5", bc);
    end
    vectors++;
    if (bus16.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy_in_done: got %b, expected 1", bus16.busy);
    end
    @(negedge clk);
    vectors++;
    if ({bus16.busy, bus16.Done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL basic_after_done: got busy=%b Done=%b, expected 0 0",
               bus16.busy, bus16.Done);
    end
    vectors++;
    if (bus16.reverse !== 16'd4321) begin
      miscompares++;
      $display("[TB] FAIL basic_hold: got %0d, expected 4321", bus16.reverse);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    run16(16'd0, lat, bc);
    vectors++;
    if (bus16.reverse !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL zero_rev: got %0d, expected 0", bus16.reverse);
    end
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("[TB] FAIL zero_latency: got %0d, expected 1", lat);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    run16(16'd60009, lat, bc);
    vectors++;
    if (bus16.reverse !== 16'd24470) begin
      miscompares++;
      $display("[TB] FAIL ovf_rev: got %0d, expected 24470", bus16.reverse);
    end
    vectors++;
    if (bus16.ovf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_flag: got %b, expected 1", bus16.ovf);
    end
    vectors++;
    if (lat !== 6) begin
      miscompares++;
      $display("[TB] FAIL ovf_latency: got %0d, expected 6", lat);
    end
  endtask

  task automatic test_trailing_zeros();
    int lat, bc;
    run16(16'd1200, lat, bc);
    vectors++;
    if (bus16.reverse !== 16'd21) begin
      miscompares++;
      $display("[TB] FAIL trail_rev: got %0d, expected 21", bus16.reverse);
    end
    vectors++;
    if (bus16.ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL trail_ovf_cleared: got %b, expected 0", bus16.ovf);
    end
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL trail_latency: got %0d, expected 5", lat);
    end
  endtask

  task automatic test_binary();
    int lat;
    run8(8'b0000_1101, lat);
    vectors++;
    if (bus8.reverse !== 8'b0000_1011) begin
      miscompares++;
      $display("[TB] FAIL bin_rev: got %b, expected 00001011", bus8.reverse);
    end
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("[TB] FAIL bin_latency: got %0d, expected 5", lat);
    end
  endtask

  task automatic test_busy_ignore();
    int dones;
    logic [15:0] rev_at_done;
    dones = 0;
    rev_at_done = '0;
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.x     = 16'd4321;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.x     = 16'd99;
    @(negedge clk);
    bus16.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (bus16.Done === 1'b1) begin
        dones++;
        rev_at_done = bus16.reverse;
      end
      @(negedge clk);
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++;
      $display("[TB] FAIL busy_ignore_dones: got %0d, expected 1", dones);
    end
    vectors++;
    if (rev_at_done !== 16'd1234) begin
      miscompares++;
      $display("[TB] FAIL busy_ignore_rev: got %0d, expected 1234", rev_at_done);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int lat, bc;
    dones = 0;
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.x     = 16'd4321;
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus16.busy, bus16.Done, bus16.ovf, bus16.reverse} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got busy=%b Done=%b ovf=%b rev=%0d, expected all 0",
               bus16.busy, bus16.Done, bus16.ovf, bus16.reverse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus16.Done === 1'b1) dones++;
      @(negedge clk);
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_no_done: got %0d Done pulses, expected 0", dones);
    end
    run16(16'd56, lat, bc);
    vectors++;
    if (bus16.reverse !== 16'd65) begin
      miscompares++;
      $display("[TB] FAIL post_reset_rev: got %0d, expected 65", bus16.reverse);
    end
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("[TB] FAIL post_reset_latency: got %0d, expected 3", lat);
    end
  endtask

  // start held high: after Done one IDLE cycle passes, then the held request
  // is accepted, so Done pulses repeat every n+3 cycles (n=1 for x=7).
  task automatic test_back_to_back();
    int first_idx, second_idx;
    first_idx  = -1;
    second_idx = -1;
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.x     = 16'd7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus16.Done === 1'b1) begin
        if (first_idx < 0) first_idx = i;
        else if (second_idx < 0) begin
          second_idx = i;
          bus16.start = 1'b0;
        end
      end
    end
    bus16.start = 1'b0;
    vectors++;
    if (second_idx - first_idx !== 4 || first_idx < 0 || second_idx < 0) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_gap: got Done at %0d and %0d, expected gap 4",
               first_idx, second_idx);
    end
    vectors++;
    if (bus16.reverse !== 16'd7) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_rev: got %0d, expected 7", bus16.reverse);
    end
  endtask

`ifdef REVERSE_PALINDROME_EN
  task automatic test_palindrome();
    int lat, bc;
    run16(16'd12321, lat, bc);
    vectors++;
    if (bus16.palindrome !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pal_12321: got %b, expected 1", bus16.palindrome);
    end
    run16(16'd12345, lat, bc);
    vectors++;
    if (bus16.palindrome !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pal_12345: got %b, expected 0", bus16.palindrome);
    end
    vectors++;
    if (bus16.reverse !== 16'd54321) begin
      miscompares++;
      $display("[TB] FAIL pal_12345_rev: got %0d, expected 54321", bus16.reverse);
    end
  endtask
`endif

  initial begin
    bus16.start = 1'b0;
    bus16.x     = '0;
    bus8.start  = 1'b0;
    bus8.x      = '0;
    budget16    = max_digits(16, 10) + 4;
    budget8     = max_digits(8, 2) + 4;
    $display("[TB] starting reverse_digits checks");
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_trailing_zeros();
    test_binary();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef REVERSE_PALINDROME_EN
    test_palindrome();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
